cust_spike_detector: RTL

//  Consumer end of the per-channel sample stream emitted by the custom HP filter: drives the

---
 rtl/cust_spike_detector.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cust_spike_detector.sv
// Purpose : consumes the per-channel filtered sample stream, flags negative threshold
//           crossings per channel (with per-channel refractory dead time held in RAM)
//           and queues {channel, timestamp, amplitude} events in a first-word-fall-through FIFO.
// Latency : a sample accepted at clock edge N pushes its event at edge N+2; o_spike_valid
//           is high in the cycle after that push when the FIFO was empty.
// Backpressure: o_chan_in_read is held low during the RAM clear sweep. With
//           CUST_SPIKE_BACKPRESSURE_EN defined it also drops when the FIFO has too few
//           free entries for the events still in flight. Without it, a hit that finds
//           the FIFO full (and no pop that cycle) is dropped and o_spike_overflow is set.
//
// Ports:
//   i_clk, i_reset_n     clock, synchronous active-low reset
//   i_chan_in_*          sample stream (offset-binary sample, channel, valid); o_chan_in_read = ready
//   i_threshold          detection magnitude (0 disables detection)
//   i_refractory         dead samples per channel after a spike
//   i_timestamp          free-running sample counter, latched when a sample is accepted
//   o_spike_*            FIFO head event, valid flag; i_spike_read pops the head
//   o_spike_overflow     sticky dropped-event flag
//   o_init_busy          refractory RAM clear sweep in progress
// Build option: CUST_SPIKE_BACKPRESSURE_EN (see backpressure note above).

module cust_spike_detector #(
    parameter int CHANNELS     = 128,
    parameter int CHANNELS_PW2 = 7,
    parameter int REFRACT_W    = 8,
    parameter int FIFO_PW2     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [15:0]             i_chan_in_sample,
    input  logic [CHANNELS_PW2-1:0] i_chan_in_num,
    input  logic                    i_chan_in_valid,
    output logic                    o_chan_in_read,
    input  logic [15:0]             i_threshold,
    input  logic [REFRACT_W-1:0]    i_refractory,
    input  logic [31:0]             i_timestamp,
    output logic [CHANNELS_PW2-1:0] o_spike_num,
    output logic [31:0]             o_spike_ts,
    output logic [15:0]             o_spike_amp,
    output logic                    o_spike_valid,
    input  logic                    i_spike_read,
    output logic                    o_spike_overflow,
    output logic                    o_init_busy
);

    localparam int DEPTH = 2 ** FIFO_PW2;
    localparam int EVT_W = CHANNELS_PW2 + 32 + 16;

    localparam logic [CHANNELS_PW2-1:0] ADDR_ONE  = 1;
    localparam logic [CHANNELS_PW2-1:0] ADDR_LAST = CHANNELS_PW2'(CHANNELS - 1);
    localparam logic [REFRACT_W-1:0]    CNT_ONE   = 1;
    localparam logic [FIFO_PW2-1:0]     PTR_ONE   = 1;
    localparam logic [FIFO_PW2:0]       CNT_FULL  = (FIFO_PW2 + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                    r_init_busy;
    logic [CHANNELS_PW2-1:0] r_init_addr;

    logic [REFRACT_W-1:0]    r_cnt_ram [CHANNELS];

    // S0: accepted sample, RAM read issued from these registers
    logic                    r_s0_vld;
    logic [15:0]             r_s0_sample;
    logic [CHANNELS_PW2-1:0] r_s0_num;
    logic [31:0]             r_s0_ts;

    // S1: sample in signed form plus the channel's refractory count
    logic                    r_s1_vld;
    logic signed [15:0]      r_s1_s;
    logic [CHANNELS_PW2-1:0] r_s1_num;
    logic [31:0]             r_s1_ts;
    logic [REFRACT_W-1:0]    r_s1_cnt;

    // Event FIFO
    logic [EVT_W-1:0]        r_fifo_mem [DEPTH];
    logic [FIFO_PW2-1:0]     r_wr_ptr;
    logic [FIFO_PW2-1:0]     r_rd_ptr;
    logic                    r_full;
    logic                    r_overflow;

    // ------------------------------------------------------------------
    // S1 evaluation
    // ------------------------------------------------------------------
    logic signed [16:0]      w_s17;
    logic signed [16:0]      w_neg_thr;
    logic                    w_cross;
    logic                    w_hit;
    logic [REFRACT_W-1:0]    w_cnt_new;
    logic                    w_fwd;

    // 17-bit compare: -threshold reaches -65535 without wrapping.
    assign w_s17     = {r_s1_s[15], r_s1_s};
    assign w_neg_thr = 17'sd0 - $signed({1'b0, i_threshold});
    assign w_cross   = (i_threshold != 16'd0) && (w_s17 < w_neg_thr);
    assign w_hit     = r_s1_vld && w_cross && (r_s1_cnt == '0);

    // Counters tick per sample of their own channel, so they only change here.
    always_comb begin
        w_cnt_new = '0;
        if (w_hit) begin
            w_cnt_new = i_refractory;
        end else if (r_s1_cnt != '0) begin
            w_cnt_new = r_s1_cnt - CNT_ONE;
        end
    end

    // S1 writes back at the same edge S0's read is taken; if both touch the same
    // channel the RAM still holds the stale count, so bypass the new value.
    assign w_fwd = r_s1_vld && (r_s1_num == r_s0_num);

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [FIFO_PW2:0]       w_count;
    logic                    w_accept;

    assign w_empty  = (r_wr_ptr == r_rd_ptr) && !r_full;
    assign w_pop    = !w_empty && i_spike_read;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_push   = w_hit && (!r_full || w_pop);
    assign w_drop   = w_hit && r_full && !w_pop;
    assign w_count  = r_full ? CNT_FULL : {1'b0, r_wr_ptr - r_rd_ptr};
    assign w_accept = i_chan_in_valid && o_chan_in_read;

`ifdef CUST_SPIKE_BACKPRESSURE_EN
    // S0 is counted whether or not it will hit: its count is not known until S1,
    // and over-counting only costs throughput, never an event.
    logic [FIFO_PW2+1:0]     w_used;
    assign w_used = (FIFO_PW2 + 2)'(w_count)
                  + (FIFO_PW2 + 2)'(r_s0_vld)
                  + (FIFO_PW2 + 2)'(w_hit);
    assign o_chan_in_read = !r_init_busy && (w_used < (FIFO_PW2 + 2)'(DEPTH - 2));
`else
    assign o_chan_in_read = !r_init_busy;
`endif

    // ------------------------------------------------------------------
    // Refractory counter RAM: clear sweep has priority, then S1 write-back.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            if (r_init_busy) begin
                r_cnt_ram[r_init_addr] <= '0;
            end else if (r_s1_vld) begin
                r_cnt_ram[r_s1_num] <= w_cnt_new;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event storage (no reset needed: occupancy lives in the pointers)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {r_s1_num, r_s1_ts, r_s1_s};
        end
    end

    // ------------------------------------------------------------------
    // Sweep, pipeline and FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_init_busy <= 1'b1;
            r_init_addr <= '0;
            r_s0_vld    <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // Clear sweep, one channel per cycle
            if (r_init_busy) begin
                r_init_addr <= r_init_addr + ADDR_ONE;
                if (r_init_addr == ADDR_LAST) begin
                    r_init_busy <= 1'b0;
                end
            end

            // S0 accept
            r_s0_vld <= w_accept;
            if (w_accept) begin
                r_s0_sample <= i_chan_in_sample;
                r_s0_num    <= i_chan_in_num;
                r_s0_ts     <= i_timestamp;
            end

            // S0 -> S1: offset binary to two's complement is an MSB flip
            r_s1_vld <= r_s0_vld;
            if (r_s0_vld) begin
                r_s1_s   <= {~r_s0_sample[15], r_s0_sample[14:0]};
                r_s1_num <= r_s0_num;
                r_s1_ts  <= r_s0_ts;
                r_s1_cnt <= w_fwd ? w_cnt_new : r_cnt_ram[r_s0_num];
            end

            // FIFO pointers; full is tracked apart from the pointers since they wrap
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_full <= ((r_wr_ptr + PTR_ONE) == r_rd_ptr);
            end else if (w_pop && !w_push) begin
                r_full <= 1'b0;
            end

`ifndef CUST_SPIKE_BACKPRESSURE_EN
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
`endif
        end
    end

`ifdef CUST_SPIKE_BACKPRESSURE_EN
    // Admission control guarantees a slot, so a drop cannot occur in this build.
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
`endif

    // ------------------------------------------------------------------
    // Outputs: FWFT head
    // ------------------------------------------------------------------
    logic [EVT_W-1:0] w_head;
    assign w_head           = r_fifo_mem[r_rd_ptr];
    assign o_spike_num      = w_head[EVT_W-1 -: CHANNELS_PW2];
    assign o_spike_ts       = w_head[47:16];
    assign o_spike_amp      = w_head[15:0];
    assign o_spike_valid    = !w_empty;
    assign o_spike_overflow = r_overflow;
    assign o_init_busy      = r_init_busy;

endmodule
